// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared state type, idle bus code and round-robin pick helper
// for the register write arbiter.
package reg_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Write bus value when nothing is written: MSB set, data field zero.
  localparam logic [4:0] WR_NOP = 5'b10000;

  // Widest requester vector the pick helper understands.
  localparam int unsigned PICK_MAX = 8;

  // Returns the first set bit of valid when scanning last+1, last+2, ... mod n.
  // Returns 0 when no bit is set; callers qualify with |valid.
  function automatic int unsigned rr_pick(input logic [7:0] valid,
                                          input int unsigned last,
                                          input int unsigned n);
    int unsigned pick;
    logic        found;
    logic [2:0]  idx;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 1; k <= PICK_MAX; k++) begin
      idx = 3'((last + k) % n);
      if ((k <= n) && !found && valid[idx]) begin
        pick  = 32'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotate-and-priority-encode of the request vector,
// starting the search just after the previous winner.
module rr_priority_pick
  import reg_arb_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [GW-1:0]      last,
  output logic [GW-1:0]      winner,
  output logic               found
);

  // Pick the next valid requester after last, wrapping around
  always_comb begin
    winner = GW'(rr_pick(8'(valid), 32'(last), 32'(NUM_REQ)));
    found  = |valid;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register bank write path between requesters
// with round-robin arbitration and a bounded burst lock. One transfer per cycle
// at most; the accepted write appears on Wr_En/Wr_D exactly one cycle later.
// Optional build macro ARB_CONFLICT_CNT_EN adds the Conflict_Cnt output.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 3,
  parameter  int NUM_REGS = 4,
  parameter  int DATA_W   = 4,
  parameter  int MAX_LOCK = 4,
  localparam int AW       = $clog2(NUM_REGS),
  localparam int GW       = $clog2(NUM_REQ)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        Req_Valid,
  input  logic [NUM_REQ-1:0]        Req_Lock,
  input  logic [NUM_REQ*AW-1:0]     Req_Addr,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
  output logic [NUM_REQ-1:0]        Req_Ready,
  output logic [NUM_REGS-1:0]       Wr_En,
  output logic [DATA_W:0]           Wr_D,
  output logic [GW-1:0]             Grant_Id,
  output logic                      Busy,
  output logic                      Err_Addr
`ifdef ARB_CONFLICT_CNT_EN
  ,
  output logic [7:0]                Conflict_Cnt
`endif
);

  localparam logic [DATA_W:0] WR_IDLE   = {1'b1, {DATA_W{1'b0}}};
  localparam logic [3:0]      LOCK_LIMIT = 4'(MAX_LOCK);
  localparam logic [GW-1:0]   LAST_INIT  = GW'(NUM_REQ - 1);

  arb_state_t          state, state_nxt;
  logic [GW-1:0]       last, last_nxt;
  logic [GW-1:0]       owner, owner_nxt;
  logic [3:0]          lock_cnt, cnt_nxt;
  logic [GW-1:0]       winner;
  logic                any_valid;
  logic [NUM_REQ-1:0]  ready;
  logic                xfer;
  logic [GW-1:0]       xfer_idx;
  logic [AW-1:0]       sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                addr_ok;
  logic [NUM_REGS-1:0] dec_en;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid  (Req_Valid),
    .last   (last),
    .winner (winner),
    .found  (any_valid)
  );

  // Arbitration FSM: decides who is ready this cycle and the next state
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    owner_nxt = owner;
    cnt_nxt   = lock_cnt;
    ready     = '0;
    xfer      = 1'b0;
    xfer_idx  = owner;
    if (!Reset) begin
      case (state)
        IDLE: begin
          xfer_idx = winner;
          if (any_valid) begin
            ready[winner] = 1'b1;
            xfer          = 1'b1;
            last_nxt      = winner;
            if (Req_Lock[winner]) begin
              state_nxt = LOCKED;
              owner_nxt = winner;
              cnt_nxt   = 4'd1;
            end
          end
        end
        LOCKED: begin
          if (Req_Valid[owner]) begin
            ready[owner] = 1'b1;
            xfer         = 1'b1;
            last_nxt     = owner;
            if (Req_Lock[owner] && (lock_cnt < LOCK_LIMIT)) begin
              cnt_nxt = lock_cnt + 4'd1;
            end else begin
              state_nxt = IDLE;
              cnt_nxt   = 4'd0;
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Arbitration state register: FSM state, round-robin pointer, lock owner and count
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      last     <= LAST_INIT;
      owner    <= '0;
      lock_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      owner    <= owner_nxt;
      lock_cnt <= cnt_nxt;
    end
  end

  // Select the accepted requester's address and data and decode the target register
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer_idx == GW'(i)) begin
        sel_addr = Req_Addr[i*AW +: AW];
        sel_data = Req_Data[i*DATA_W +: DATA_W];
      end
    end
    addr_ok = (32'(sel_addr) < NUM_REGS);
    dec_en  = '0;
    if (addr_ok) begin
      dec_en[sel_addr] = 1'b1;
    end
  end

  // Output stage: one-cycle write pulse, error pulse and sticky grant index
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Wr_En    <= '0;
      Wr_D     <= WR_IDLE;
      Grant_Id <= '0;
      Err_Addr <= 1'b0;
    end else begin
      Wr_En    <= '0;
      Wr_D     <= WR_IDLE;
      Err_Addr <= 1'b0;
      if (xfer) begin
        Grant_Id <= xfer_idx;
        if (addr_ok) begin
          Wr_En <= dec_en;
          Wr_D  <= {1'b0, sel_data};
        end else begin
          Err_Addr <= 1'b1;
        end
      end
    end
  end

  // Status outputs visible to requesters
  always_comb begin
    Req_Ready = ready;
    Busy      = (state == LOCKED);
  end

`ifdef ARB_CONFLICT_CNT_EN
  logic [NUM_REQ-1:0] owner_mask;
  logic               conflict;

  // Flag cycles where some valid requester was held off by arbitration or a lock
  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    conflict          = 1'b0;
    if (!Reset) begin
      if (($countones(Req_Valid) >= 2) && xfer) begin
        conflict = 1'b1;
      end
      if ((state == LOCKED) && ((Req_Valid & ~owner_mask) != '0)) begin
        conflict = 1'b1;
      end
    end
  end

  // Saturating contention counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Conflict_Cnt <= 8'd0;
    end else if (conflict && (Conflict_Cnt != 8'hFF)) begin
      Conflict_Cnt <= Conflict_Cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: scoreboard bench for the register write arbiter.
// Built with NUM_REGS=3 so that address 3 is out of range.
module tb_reg_write_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int NUM_REGS = 3;
  localparam int DATA_W   = 4;
  localparam int MAX_LOCK = 4;

  typedef struct packed {
    logic [2:0] en;
    logic [4:0] d;
    logic       err;
    logic [1:0] gid;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [2:0]  Req_Valid;
  logic [2:0]  Req_Lock;
  logic [5:0]  Req_Addr;
  logic [11:0] Req_Data;
  logic [2:0]  Req_Ready;
  logic [2:0]  Wr_En;
  logic [4:0]  Wr_D;
  logic [1:0]  Grant_Id;
  logic        Busy;
  logic        Err_Addr;
`ifdef ARB_CONFLICT_CNT_EN
  logic [7:0]  Conflict_Cnt;
`endif

  int         tests    = 0;
  int         failures = 0;
  logic [1:0] exp_gid  = 2'd0;
  exp_t       sb[$];

  reg_write_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Req_Valid (Req_Valid),
    .Req_Lock  (Req_Lock),
    .Req_Addr  (Req_Addr),
    .Req_Data  (Req_Data),
    .Req_Ready (Req_Ready),
    .Wr_En     (Wr_En),
    .Wr_D      (Wr_D),
    .Grant_Id  (Grant_Id),
    .Busy      (Busy),
    .Err_Addr  (Err_Addr)
`ifdef ARB_CONFLICT_CNT_EN
    ,
    .Conflict_Cnt (Conflict_Cnt)
`endif
  );

  always #5 Clock = ~Clock;

  // Expected write-stage contents for the cycle after the current inputs.
  function automatic void push_expect(input logic rst, input logic [2:0] rdy);
    exp_t       e;
    int         idx;
    logic [1:0] a;
    e.en  = 3'b000;
    e.d   = 5'b10000;
    e.err = 1'b0;
    if (rst) begin
      exp_gid = 2'd0;
    end else if (rdy != 3'b000) begin
      idx     = rdy[1] ? 1 : (rdy[2] ? 2 : 0);
      exp_gid = 2'(idx);
      a       = Req_Addr[idx*2 +: 2];
      if (a < 2'd3) begin
        e.en = 3'b001 << a;
        e.d  = {1'b0, Req_Data[idx*4 +: 4]};
      end else begin
        e.err = 1'b1;
      end
    end
    e.gid = exp_gid;
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    Reset     = 1'b1;
    Req_Valid = 3'b111;
    Req_Lock  = 3'b000;
    Req_Addr  = 6'b10_01_00;
    Req_Data  = 12'hCBA;
    #1;
    tests++;
    if (Req_Ready !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %b, expected 000", Req_Ready);
    end
    @(posedge Clock); #1;
    tests++;
    if ({Wr_En, Wr_D, Err_Addr, Grant_Id, Busy} !== {3'b000, 5'b10000, 1'b0, 2'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got en=%b d=%b err=%b gid=%0d busy=%b, expected en=000 d=10000 err=0 gid=0 busy=0",
               Wr_En, Wr_D, Err_Addr, Grant_Id, Busy);
    end
    Reset     = 1'b0;
    Req_Valid = 3'b000;
    #1;
    tests++;
    if (Req_Ready !== 3'b000) begin
      failures++;
      $display("[TB] FAIL post_reset_ready: got %b, expected 000", Req_Ready);
    end
    @(posedge Clock); #1;
    tests++;
    if ({Wr_En, Wr_D, Err_Addr, Grant_Id, Busy} !== {3'b000, 5'b10000, 1'b0, 2'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: got en=%b d=%b err=%b gid=%0d busy=%b, expected en=000 d=10000 err=0 gid=0 busy=0",
               Wr_En, Wr_D, Err_Addr, Grant_Id, Busy);
    end
    sb.delete();
    exp_gid = 2'd0;
  endtask

  task automatic test_round_robin();
    logic [2:0] vld [4] = '{3'b111, 3'b111, 3'b111, 3'b000};
    logic [2:0] rdy [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
    exp_t e;
    Req_Lock = 3'b000;
    Req_Addr = 6'b10_01_00;
    Req_Data = 12'hCBA;
    for (int c = 0; c < 4; c++) begin
      Req_Valid = vld[c];
      #1;
      tests++;
      if (Req_Ready !== rdy[c]) begin
        failures++;
        $display("[TB] FAIL rr_ready cycle %0d: got %b, expected %b", c, Req_Ready, rdy[c]);
      end
      push_expect(1'b0, rdy[c]);
      @(posedge Clock); #1;
      e = sb.pop_front();
      tests++;
      if ({Wr_En, Wr_D, Err_Addr, Grant_Id} !== {e.en, e.d, e.err, e.gid}) begin
        failures++;
        $display("[TB] FAIL rr_write cycle %0d: got en=%b d=%b err=%b gid=%0d, expected en=%b d=%b err=%b gid=%0d",
                 c, Wr_En, Wr_D, Err_Addr, Grant_Id, e.en, e.d, e.err, e.gid);
      end
    end
  endtask

  task automatic test_idle_hold();
    logic [5:0]  adr [3] = '{6'b00_00_01, 6'b01_10_00, 6'b11_11_11};
    logic [11:0] dat [3] = '{12'h123, 12'h456, 12'h789};
    exp_t e;
    Req_Valid = 3'b000;
    Req_Lock  = 3'b000;
    for (int c = 0; c < 3; c++) begin
      Req_Addr = adr[c];
      Req_Data = dat[c];
      #1;
      tests++;
      if ({Req_Ready, Busy} !== {3'b000, 1'b0}) begin
        failures++;
        $display("[TB] FAIL idle_ready cycle %0d: got ready=%b busy=%b, expected ready=000 busy=0", c, Req_Ready, Busy);
      end
      push_expect(1'b0, 3'b000);
      @(posedge Clock); #1;
      e = sb.pop_front();
      tests++;
      if ({Wr_En, Wr_D, Err_Addr, Grant_Id} !== {e.en, e.d, e.err, e.gid}) begin
        failures++;
        $display("[TB] FAIL idle_write cycle %0d: got en=%b d=%b err=%b gid=%0d, expected en=%b d=%b err=%b gid=%0d",
                 c, Wr_En, Wr_D, Err_Addr, Grant_Id, e.en, e.d, e.err, e.gid);
      end
    end
  endtask

  task automatic test_lock_release();
    logic [2:0] vld [7] = '{3'b010, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b000};
    logic [2:0] lck [7] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
    logic [2:0] rdy [7] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000};
    logic       bsy [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_t e;
    Req_Addr = 6'b10_01_00;
    Req_Data = 12'hCBA;
    for (int c = 0; c < 7; c++) begin
      Req_Valid = vld[c];
      Req_Lock  = lck[c];
      #1;
      tests++;
      if ({Req_Ready, Busy} !== {rdy[c], bsy[c]}) begin
        failures++;
        $display("[TB] FAIL lock_ready cycle %0d: got ready=%b busy=%b, expected ready=%b busy=%b",
                 c, Req_Ready, Busy, rdy[c], bsy[c]);
      end
      push_expect(1'b0, rdy[c]);
      @(posedge Clock); #1;
      e = sb.pop_front();
      tests++;
      if ({Wr_En, Wr_D, Err_Addr, Grant_Id} !== {e.en, e.d, e.err, e.gid}) begin
        failures++;
        $display("[TB] FAIL lock_write cycle %0d: got en=%b d=%b err=%b gid=%0d, expected en=%b d=%b err=%b gid=%0d",
                 c, Wr_En, Wr_D, Err_Addr, Grant_Id, e.en, e.d, e.err, e.gid);
      end
    end
  endtask

  task automatic test_lock_drop();
    logic [2:0] vld [5] = '{3'b010, 3'b011, 3'b001, 3'b011, 3'b000};
    logic [2:0] lck [5] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000};
    logic [2:0] rdy [5] = '{3'b010, 3'b010, 3'b000, 3'b001, 3'b000};
    logic [1:0] bsy [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
    exp_t e;
    Req_Addr = 6'b10_01_00;
    Req_Data = 12'hCBA;
    for (int c = 0; c < 5; c++) begin
      Req_Valid = vld[c];
      Req_Lock  = lck[c];
      #1;
      tests++;
      if (Req_Ready !== rdy[c]) begin
        failures++;
        $display("[TB] FAIL drop_ready cycle %0d: got %b, expected %b", c, Req_Ready, rdy[c]);
      end
      if (bsy[c] != 2'd2) begin
        tests++;
        if (Busy !== bsy[c][0]) begin
          failures++;
          $display("[TB] FAIL drop_busy cycle %0d: got %b, expected %b", c, Busy, bsy[c][0]);
        end
      end
      push_expect(1'b0, rdy[c]);
      @(posedge Clock); #1;
      e = sb.pop_front();
      tests++;
      if ({Wr_En, Wr_D, Err_Addr, Grant_Id} !== {e.en, e.d, e.err, e.gid}) begin
        failures++;
        $display("[TB] FAIL drop_write cycle %0d: got en=%b d=%b err=%b gid=%0d, expected en=%b d=%b err=%b gid=%0d",
                 c, Wr_En, Wr_D, Err_Addr, Grant_Id, e.en, e.d, e.err, e.gid);
      end
    end
  endtask

  task automatic test_addr_err();
    logic [2:0] vld [4] = '{3'b100, 3'b000, 3'b001, 3'b000};
    logic [2:0] rdy [4] = '{3'b100, 3'b000, 3'b001, 3'b000};
    exp_t e;
    Req_Lock = 3'b000;
    Req_Addr = 6'b11_01_00;
    Req_Data = 12'h5BA;
    for (int c = 0; c < 4; c++) begin
      Req_Valid = vld[c];
      #1;
      tests++;
      if (Req_Ready !== rdy[c]) begin
        failures++;
        $display("[TB] FAIL err_ready cycle %0d: got %b, expected %b", c, Req_Ready, rdy[c]);
      end
      push_expect(1'b0, rdy[c]);
      @(posedge Clock); #1;
      e = sb.pop_front();
      tests++;
      if ({Wr_En, Wr_D, Err_Addr, Grant_Id} !== {e.en, e.d, e.err, e.gid}) begin
        failures++;
        $display("[TB] FAIL err_write cycle %0d: got en=%b d=%b err=%b gid=%0d, expected en=%b d=%b err=%b gid=%0d",
                 c, Wr_En, Wr_D, Err_Addr, Grant_Id, e.en, e.d, e.err, e.gid);
      end
    end
  endtask

  task automatic test_reset_midlock();
    logic       rst [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] vld [5] = '{3'b001, 3'b001, 3'b001, 3'b111, 3'b000};
    logic [2:0] lck [5] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
    logic [2:0] rdy [5] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b000};
    logic [1:0] bsy [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
    exp_t e;
    Req_Addr = 6'b10_01_00;
    Req_Data = 12'hCBA;
    for (int c = 0; c < 5; c++) begin
      Reset     = rst[c];
      Req_Valid = vld[c];
      Req_Lock  = lck[c];
      #1;
      tests++;
      if (Req_Ready !== rdy[c]) begin
        failures++;
        $display("[TB] FAIL rstlock_ready cycle %0d: got %b, expected %b", c, Req_Ready, rdy[c]);
      end
      if (bsy[c] != 2'd2) begin
        tests++;
        if (Busy !== bsy[c][0]) begin
          failures++;
          $display("[TB] FAIL rstlock_busy cycle %0d: got %b, expected %b", c, Busy, bsy[c][0]);
        end
      end
      push_expect(rst[c], rdy[c]);
      @(posedge Clock); #1;
      e = sb.pop_front();
      tests++;
      if ({Wr_En, Wr_D, Err_Addr, Grant_Id} !== {e.en, e.d, e.err, e.gid}) begin
        failures++;
        $display("[TB] FAIL rstlock_write cycle %0d: got en=%b d=%b err=%b gid=%0d, expected en=%b d=%b err=%b gid=%0d",
                 c, Wr_En, Wr_D, Err_Addr, Grant_Id, e.en, e.d, e.err, e.gid);
      end
    end
    Reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] vld [5] = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b000};
    logic [2:0] rdy [5] = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b000};
    logic [11:0] dat [5] = '{12'h321, 12'h654, 12'h987, 12'hCBA, 12'h000};
    exp_t e;
    Req_Lock = 3'b000;
    Req_Addr = 6'b00_10_01;
    for (int c = 0; c < 5; c++) begin
      Req_Valid = vld[c];
      Req_Data  = dat[c];
      #1;
      tests++;
      if (Req_Ready !== rdy[c]) begin
        failures++;
        $display("[TB] FAIL b2b_ready cycle %0d: got %b, expected %b", c, Req_Ready, rdy[c]);
      end
      push_expect(1'b0, rdy[c]);
      @(posedge Clock); #1;
      e = sb.pop_front();
      tests++;
      if ({Wr_En, Wr_D, Err_Addr, Grant_Id} !== {e.en, e.d, e.err, e.gid}) begin
        failures++;
        $display("[TB] FAIL b2b_write cycle %0d: got en=%b d=%b err=%b gid=%0d, expected en=%b d=%b err=%b gid=%0d",
                 c, Wr_En, Wr_D, Err_Addr, Grant_Id, e.en, e.d, e.err, e.gid);
      end
    end
  endtask

  initial begin
    Reset     = 1'b1;
    Req_Valid = 3'b000;
    Req_Lock  = 3'b000;
    Req_Addr  = 6'b0;
    Req_Data  = 12'h0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    test_reset();
    test_round_robin();
    test_idle_hold();
    test_lock_release();
    test_lock_drop();
    test_addr_err();
    test_reset_midlock();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
